// File: rtl/sum_serializer.sv
// Buffers sum samples in a small FIFO and sends each one as a UART-style frame on out_tx:
// start bit, DATA_W data bits LSB first, optional parity bit (SUM_SERIALIZER_PARITY_EN), stop bit.
module sum_serializer #(
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          out_tx,
  output logic                          out_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef SUM_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;
  state_t            state_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              tx_reg;
`ifdef SUM_SERIALIZER_PARITY_EN
  logic              parity_reg;
`endif

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign in_ready   = (count_reg != CNT_FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == ST_IDLE) && (count_reg != '0);
  // Combinational head read keeps the one-edge push-to-start latency.
  assign head       = mem_reg[rd_ptr_reg];
  assign shift_next = shift_reg >> 1;

  assign out_tx     = tx_reg;
  assign out_busy   = (state_reg != ST_IDLE);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

  // Sample storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= ST_IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef SUM_SERIALIZER_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
      if (in_valid && !in_ready) overflow_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            shift_reg   <= head;
`ifdef SUM_SERIALIZER_PARITY_EN
            parity_reg  <= ^head;
`endif
            state_reg   <= ST_START;
            tx_reg      <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
          end
        end
        ST_START: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            state_reg   <= ST_DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
`ifdef SUM_SERIALIZER_PARITY_EN
              state_reg <= ST_PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              shift_reg   <= shift_next;
              tx_reg      <= shift_next[0];
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
`ifdef SUM_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            state_reg   <= ST_STOP;
            tx_reg      <= 1'b1;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          // Returning to IDLE here guarantees at least one idle cycle between frames.
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_serializer.sv
// Directed bench for sum_serializer: one instance at BIT_DIV=4, one at BIT_DIV=1.
module tb_sum_serializer;

`ifdef SUM_SERIALIZER_PARITY_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int POP2 = NB + 2;

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b;
  logic       in_valid_a, in_valid_b;
  logic [2:0] in_data_a, in_data_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [2:0] count_a, count_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] data;
    logic [5:0] exp_np;
    logic [5:0] exp_p;
  } vec_t;
  vec_t vecs [6];
  logic [2:0] t6_data [10];

  always #5 clk = ~clk;

  sum_serializer #(.DATA_W(3), .FIFO_DEPTH(4), .BIT_DIV(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .out_tx(tx_a), .out_busy(busy_a), .fifo_count(count_a),
    .overflow(ovf_a));

  sum_serializer #(.DATA_W(3), .FIFO_DEPTH(4), .BIT_DIV(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out_tx(tx_b), .out_busy(busy_b), .fifo_count(count_b),
    .overflow(ovf_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic get_busy(input int w);
    return (w != 0) ? busy_b : busy_a;
  endfunction

  // Reference frame: bit i is the i-th bit on the line.
  function automatic logic [5:0] frame_bits(input logic [2:0] d);
    logic [5:0] f;
    f = '0;
    f[0]   = 1'b0;
    f[3:1] = d;
`ifdef SUM_SERIALIZER_PARITY_EN
    f[4] = ^d;
    f[5] = 1'b1;
`else
    f[4] = 1'b1;
`endif
    return f;
  endfunction

  // mode 0: start is at the next negedge; 1: search for start; 2: exactly one idle cycle first
  task automatic check_frame(input int w, input logic [5:0] exp, input int mode, input string tag);
    int  div;
    int  k;
    bit  found;
    div = (w != 0) ? 1 : 4;
    if (mode == 1) begin
      found = 0;
      k = 0;
      while (!found && k < 400) begin
        @(negedge clk);
        if (get_tx(w) === 1'b0) found = 1;
        k++;
      end
      chk($sformatf("%s start_seen", tag), found, 1);
      if (!found) return;
    end else begin
      if (mode == 2) begin
        @(negedge clk);
        chk($sformatf("%s gap_tx", tag), get_tx(w), 1);
        chk($sformatf("%s gap_busy", tag), get_busy(w), 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < div; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        chk($sformatf("%s bit%0d c%0d tx", tag, i, c), get_tx(w), exp[i]);
        chk($sformatf("%s bit%0d c%0d busy", tag, i, c), get_busy(w), 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic acc;
    logic [5:0] exp;

    vecs[0] = '{data: 3'b101, exp_np: 6'b011010, exp_p: 6'b101010};
    vecs[1] = '{data: 3'b011, exp_np: 6'b010110, exp_p: 6'b100110};
    vecs[2] = '{data: 3'b111, exp_np: 6'b011110, exp_p: 6'b111110};
    vecs[3] = '{data: 3'b000, exp_np: 6'b010000, exp_p: 6'b100000};
    vecs[4] = '{data: 3'b110, exp_np: 6'b011100, exp_p: 6'b101100};
    vecs[5] = '{data: 3'b100, exp_np: 6'b011000, exp_p: 6'b111000};
    t6_data = '{3'd3, 3'd5, 3'd6, 3'd1, 3'd7, 3'd0, 3'd2, 3'd4, 3'd5, 3'd3};

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_data_a = '0; in_data_b = '0;
    repeat (3) @(negedge clk);
    chk("reset tx_a", tx_a, 1);
    chk("reset busy_a", busy_a, 0);
    chk("reset count_a", count_a, 0);
    chk("reset ready_a", in_ready_a, 1);
    chk("reset ovf_a", ovf_a, 0);
    chk("reset tx_b", tx_b, 1);
    chk("reset count_b", count_b, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // Single frames from the vector table (push into empty FIFO, start one edge later).
    for (int v = 0; v < 6; v++) begin
`ifdef SUM_SERIALIZER_PARITY_EN
      exp = vecs[v].exp_p;
`else
      exp = vecs[v].exp_np;
`endif
      in_valid_a = 1'b1;
      in_data_a  = vecs[v].data;
      @(posedge clk);
      @(negedge clk);
      in_valid_a = 1'b0;
      chk($sformatf("vec%0d count_after_push", v), count_a, 1);
      chk($sformatf("vec%0d busy_after_push", v), busy_a, 0);
      check_frame(0, exp, 0, $sformatf("vec%0d d=%b", v, vecs[v].data));
      @(negedge clk);
      chk($sformatf("vec%0d idle_tx", v), tx_a, 1);
      chk($sformatf("vec%0d idle_busy", v), busy_a, 0);
      chk($sformatf("vec%0d idle_count", v), count_a, 0);
    end

    // Burst of 8 with the FIFO filling up: 0..4 accepted, the rest refused.
    fork
      begin
        for (int j = 0; j < 8; j++) begin
          chk($sformatf("burst ready c%0d", j), in_ready_a, (j < 5) ? 1 : 0);
          in_valid_a = 1'b1;
          in_data_a  = 3'(j);
          @(posedge clk);
          @(negedge clk);
        end
        in_valid_a = 1'b0;
        chk("burst overflow", ovf_a, 1);
      end
      begin
        check_frame(0, frame_bits(3'd0), 1, "burst f0");
        for (int f = 1; f < 5; f++)
          check_frame(0, frame_bits(3'(f)), 2, $sformatf("burst f%0d", f));
      end
    join
    repeat (3) @(negedge clk);
    chk("burst end tx", tx_a, 1);
    chk("burst end busy", busy_a, 0);
    chk("burst end count", count_a, 0);
    chk("burst ovf sticky", ovf_a, 1);

    // Reset in the middle of data bit d1, with one sample still queued.
    in_valid_a = 1'b1;
    in_data_a  = 3'b101;
    @(posedge clk);
    @(negedge clk);
    in_data_a  = 3'b000;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    chk("midrst start tx", tx_a, 0);
    chk("midrst count", count_a, 1);
    repeat (8) @(negedge clk);
    chk("midrst d1 tx", tx_a, 0);
    #2 rst_n_a = 1'b0;
    #1;
    chk("midrst async tx", tx_a, 1);
    chk("midrst async busy", busy_a, 0);
    chk("midrst async count", count_a, 0);
    chk("midrst async ovf", ovf_a, 0);
    chk("midrst async ready", in_ready_a, 1);
    @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    chk("postrst idle tx", tx_a, 1);
    in_valid_a = 1'b1;
    in_data_a  = 3'b110;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    check_frame(0, frame_bits(3'b110), 0, "postrst");
    @(negedge clk);
    chk("postrst end count", count_a, 0);
    chk("postrst end busy", busy_a, 0);

    // BIT_DIV=1: push coinciding with a pop at count 2, then ten frames through pointer wrap.
    idx = 0;
    fork
      begin
        for (int cyc = 0; idx < 10 && cyc < 300; cyc++) begin
          if (cyc == POP2) begin
            chk("samepp count_before", count_b, 2);
            chk("samepp busy_before", busy_b, 0);
          end
          if ((cyc < 3) || (cyc >= POP2 && in_ready_b)) begin
            in_valid_b = 1'b1;
            in_data_b  = t6_data[idx];
            acc = 1'b1;
          end else begin
            in_valid_b = 1'b0;
            acc = 1'b0;
          end
          @(posedge clk);
          @(negedge clk);
          if (acc) idx++;
          if (cyc == POP2) begin
            chk("samepp count_after", count_b, 2);
            chk("samepp busy_after", busy_b, 1);
            chk("samepp tx_after", tx_b, 0);
          end
        end
        in_valid_b = 1'b0;
        chk("wrap all pushed", idx, 10);
      end
      begin
        check_frame(1, frame_bits(t6_data[0]), 1, "wrap f0");
        for (int f = 1; f < 10; f++)
          check_frame(1, frame_bits(t6_data[f]), 2, $sformatf("wrap f%0d", f));
      end
    join
    @(negedge clk);
    chk("wrap end count", count_b, 0);
    chk("wrap end busy", busy_b, 0);
    chk("wrap end tx", tx_b, 1);
    chk("wrap end ovf", ovf_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
